inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Parametrised dual-port instruction queue between the ICache fetch stage and the dual-issue stage.
- Accepts 0/1/2 instructions per cycle from fetch and delivers 0/1/2 per cycle to issue.
- Provides exact occupancy tracking, per-slot output valids, a margin-aware full signal and flush.
- Replaces valid-bit-array tracking with an explicit occupancy counter so full/empty are unambiguous at pointer wrap.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- DEPTH_LOG2, 4, log2(DEPTH); pointer width.
- INST_W, 32, instruction word width.
- ADDR_W, 32, instruction address width.
- FULL_MARGIN, 2, extra free slots reserved for in-flight fetch responses when computing full_o.
- CORR_W, 8, branch-predictor side-band width per entry; only used with BPU_CORR_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all entries.
- push1_valid_i  in  1  fetch slot 1 valid.
- push2_valid_i  in  1  fetch slot 2 valid; honoured only with push1_valid_i.
- push1_inst_i / push2_inst_i  in  INST_W  fetched instructions.
- push1_addr_i / push2_addr_i  in  ADDR_W  fetched instruction addresses.
- full_o  out  1  fetch must stall.
- pop_cnt_i  in  2  issue consumed 0/1/2 entries this cycle; 3 is treated as 2.
- out1_valid_o / out2_valid_o  out  1  head / head+1 entry present.
- out1_inst_o / out2_inst_o  out  INST_W  entry at head / head+1.
- out1_addr_o / out2_addr_o  out  ADDR_W  address at head / head+1.
- count_o  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - head and tail pointers, DEPTH_LOG2 bits, wrap modulo DEPTH.
  - count register, DEPTH_LOG2+1 bits.
  - Storage arrays are not reset.
- Reset (async):
  - head=0, tail=0, count=0.
  - Hence out1_valid_o=0, out2_valid_o=0, full_o=0, count_o=0.
  - Data outputs are don't-care while their valid is 0.
- Push:
  - push_n = 2 if push1&push2, 1 if push1 only, else 0.
  - push2 without push1 is ignored.
  - Push is accepted only if count + push_n <= DEPTH. Otherwise the whole push is dropped, with no partial write and no state change from the push; upstream must honour full_o.
  - Slot 1 is written to tail, slot 2 to tail+1; tail += push_n.
- Pop:
  - pop_eff = min(pop_cnt_i, count), evaluated on pre-update count, so pop never underflows.
  - head += pop_eff.
- Simultaneous push and pop:
  - count_next = count + push_acc - pop_eff.
  - Pop sees only entries present at the start of the cycle; there is no fetch-to-output bypass.
  - Push acceptance uses the pre-pop count (conservative).
- Flush: has priority over push and pop. head=tail=count=0 next cycle; same-cycle push is discarded.
- Outputs (combinational from registers; 0-cycle read latency):
  - out1 reads from head, out2 from head+1 (wrapped).
  - out1_valid_o = (count>=1); out2_valid_o = (count>=2).
- full_o (combinational from count) = (count > DEPTH - 2 - FULL_MARGIN).
- Latency: an entry pushed in cycle N is visible at the outputs in cycle N+1.
- Wrap-around: a two-entry push or pop that crosses index DEPTH-1 wraps to index 0 correctly.

Optional Feature:
- Macro: INST_QUEUE_BPU_CORR_EN.
- Defined:
  - Adds inputs push1_corr_i / push2_corr_i [CORR_W] and outputs out1_corr_o / out2_corr_o [CORR_W].
  - These are stored per entry alongside inst/addr with identical push, pop, flush and wrap semantics.
- Undefined: the ports and storage are absent; CORR_W is unused.

Test Plan:
- Reset, then push pairs (0x11,0x1000)/(0x22,0x1004) -> next cycle count_o=2, out1_inst_o=0x11, out2_addr_o=0x1004, both valids=1.
- DEPTH=16, FULL_MARGIN=2: push 12 entries with no pop -> full_o=0 at count 12, full_o=1 at count 13. A 2-push at count 15 is dropped (count stays 15); a 1-push at count 15 gives count 16.
- count=1 with pop_cnt_i=2 -> pop_eff=1, count_o=0, head+1. A same-cycle 2-push gives count_o=2, and out1 shows the first pushed instruction.
- Fill at head=14 with two 2-pushes, then pop 2 twice -> entries read in order across the 15->0 wrap; addresses are monotonic.
- flush asserted with push2 and pop_cnt_i=1 at count=6 -> next cycle count_o=0, both valids=0, full_o=0. A subsequent push lands at index 0.
- rst asserted mid-cycle at count=9 -> outputs clear immediately, without waiting for a clock edge. With INST_QUEUE_BPU_CORR_EN defined, pushed corr 0xA5 reappears on out1_corr_o with the matching instruction.

Source files
------------

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : inst_queue
// Purpose  : Dual-port (0/1/2 in, 0/1/2 out) instruction queue between fetch
//            and dual issue. Optional macro INST_QUEUE_BPU_CORR_EN adds a
//            per-entry branch-predictor side-band field.
// Revision : 1.0 - initial release
// ============================================================================
module inst_queue #(
   parameter int DEPTH       = 16,
   parameter int DEPTH_LOG2  = 4,
   parameter int INST_W      = 32,
   parameter int ADDR_W      = 32,
   parameter int FULL_MARGIN = 2,
   parameter int CORR_W      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  push1_valid_i,
   input  logic                  push2_valid_i,
   input  logic [INST_W-1:0]     push1_inst_i,
   input  logic [INST_W-1:0]     push2_inst_i,
   input  logic [ADDR_W-1:0]     push1_addr_i,
   input  logic [ADDR_W-1:0]     push2_addr_i,
`ifdef INST_QUEUE_BPU_CORR_EN
   input  logic [CORR_W-1:0]     push1_corr_i,
   input  logic [CORR_W-1:0]     push2_corr_i,
   output logic [CORR_W-1:0]     out1_corr_o,
   output logic [CORR_W-1:0]     out2_corr_o,
`endif
   output logic                  full_o,
   input  logic [1:0]            pop_cnt_i,
   output logic                  out1_valid_o,
   output logic                  out2_valid_o,
   output logic [INST_W-1:0]     out1_inst_o,
   output logic [INST_W-1:0]     out2_inst_o,
   output logic [ADDR_W-1:0]     out1_addr_o,
   output logic [ADDR_W-1:0]     out2_addr_o,
   output logic [DEPTH_LOG2:0]   count_o
);

   localparam int CW = DEPTH_LOG2 + 1;
   localparam int SW = DEPTH_LOG2 + 2;
   localparam logic [CW-1:0] c_full_thr = CW'(DEPTH - 2 - FULL_MARGIN);
   localparam logic [SW-1:0] c_depth    = SW'(DEPTH);

   if (((1 << DEPTH_LOG2) != DEPTH) || (DEPTH < 4) || (CORR_W < 1)) begin : g_param_check
      $error("inst_queue: illegal parameter combination");
   end

   logic [DEPTH_LOG2-1:0] r_head;
   logic [DEPTH_LOG2-1:0] r_tail;
   logic [CW-1:0]         r_count;

   logic [INST_W-1:0] r_inst_mem [DEPTH];
   logic [ADDR_W-1:0] r_addr_mem [DEPTH];

   logic [1:0]            w_push_n;
   logic                  w_push_ok;
   logic [1:0]            w_push_acc;
   logic [1:0]            w_pop_req;
   logic [1:0]            w_pop_eff;
   logic [DEPTH_LOG2-1:0] w_head_p1;
   logic [DEPTH_LOG2-1:0] w_tail_p1;

   always_comb begin
      w_push_n = 2'd0;
      if (push1_valid_i) begin
         w_push_n = push2_valid_i ? 2'd2 : 2'd1;
      end
      // Acceptance is judged on the pre-pop occupancy, so a full queue never
      // relies on a same-cycle pop to make room.
      w_push_ok  = ((SW'(r_count) + SW'(w_push_n)) <= c_depth);
      w_push_acc = w_push_ok ? w_push_n : 2'd0;
      w_pop_req  = (pop_cnt_i == 2'd3) ? 2'd2 : pop_cnt_i;
      w_pop_eff  = (r_count < CW'(w_pop_req)) ? r_count[1:0] : w_pop_req;
      w_head_p1  = r_head + 1'b1;
      w_tail_p1  = r_tail + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= r_head + DEPTH_LOG2'(w_pop_eff);
         r_tail  <= r_tail + DEPTH_LOG2'(w_push_acc);
         r_count <= r_count + CW'(w_push_acc) - CW'(w_pop_eff);
      end
   end

   // Storage carries no reset; validity is defined purely by r_count.
   always_ff @(posedge clk) begin
      if (!flush && (w_push_acc != 2'd0)) begin
         r_inst_mem[r_tail] <= push1_inst_i;
         r_addr_mem[r_tail] <= push1_addr_i;
         if (w_push_acc == 2'd2) begin
            r_inst_mem[w_tail_p1] <= push2_inst_i;
            r_addr_mem[w_tail_p1] <= push2_addr_i;
         end
      end
   end

`ifdef INST_QUEUE_BPU_CORR_EN
   logic [CORR_W-1:0] r_corr_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (!flush && (w_push_acc != 2'd0)) begin
         r_corr_mem[r_tail] <= push1_corr_i;
         if (w_push_acc == 2'd2) begin
            r_corr_mem[w_tail_p1] <= push2_corr_i;
         end
      end
   end

   assign out1_corr_o = r_corr_mem[r_head];
   assign out2_corr_o = r_corr_mem[w_head_p1];
`endif

   assign out1_inst_o  = r_inst_mem[r_head];
   assign out2_inst_o  = r_inst_mem[w_head_p1];
   assign out1_addr_o  = r_addr_mem[r_head];
   assign out2_addr_o  = r_addr_mem[w_head_p1];
   assign out1_valid_o = (r_count >= CW'(1));
   assign out2_valid_o = (r_count >= CW'(2));
   assign full_o       = (r_count > c_full_thr);
   assign count_o      = r_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_queue
// Purpose  : Directed, table-driven self-checking bench for inst_queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        push1_valid_i, push2_valid_i;
   logic [31:0] push1_inst_i, push2_inst_i;
   logic [31:0] push1_addr_i, push2_addr_i;
   logic        full_o;
   logic [1:0]  pop_cnt_i;
   logic        out1_valid_o, out2_valid_o;
   logic [31:0] out1_inst_o, out2_inst_o;
   logic [31:0] out1_addr_o, out2_addr_o;
   logic [4:0]  count_o;
`ifdef INST_QUEUE_BPU_CORR_EN
   logic [7:0]  push1_corr_i, push2_corr_i;
   logic [7:0]  out1_corr_o, out2_corr_o;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   inst_queue dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .push1_valid_i (push1_valid_i),
      .push2_valid_i (push2_valid_i),
      .push1_inst_i  (push1_inst_i),
      .push2_inst_i  (push2_inst_i),
      .push1_addr_i  (push1_addr_i),
      .push2_addr_i  (push2_addr_i),
`ifdef INST_QUEUE_BPU_CORR_EN
      .push1_corr_i  (push1_corr_i),
      .push2_corr_i  (push2_corr_i),
      .out1_corr_o   (out1_corr_o),
      .out2_corr_o   (out2_corr_o),
`endif
      .full_o        (full_o),
      .pop_cnt_i     (pop_cnt_i),
      .out1_valid_o  (out1_valid_o),
      .out2_valid_o  (out2_valid_o),
      .out1_inst_o   (out1_inst_o),
      .out2_inst_o   (out2_inst_o),
      .out1_addr_o   (out1_addr_o),
      .out2_addr_o   (out2_addr_o),
      .count_o       (count_o)
   );

   typedef struct {
      logic        p1, p2;
      logic [31:0] i1, i2;
      logic [1:0]  pop;
      logic        fl;
      logic [4:0]  cnt;
      logic        full;
      logic [31:0] e1, e2;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [31:0] addr_of(input logic [31:0] inst);
      return 32'h0000_2000 + {inst[29:0], 2'b00};
   endfunction

   function automatic vec_t mk(input logic p1, input logic p2, input logic [31:0] i1,
                               input logic [31:0] i2, input logic [1:0] pop, input logic fl,
                               input logic [4:0] cnt, input logic full,
                               input logic [31:0] e1, input logic [31:0] e2);
      vec_t v;
      v.p1 = p1; v.p2 = p2; v.i1 = i1; v.i2 = i2; v.pop = pop; v.fl = fl;
      v.cnt = cnt; v.full = full; v.e1 = e1; v.e2 = e2;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      flush = 1'b0; push1_valid_i = 1'b0; push2_valid_i = 1'b0;
      push1_inst_i = '0; push2_inst_i = '0; push1_addr_i = '0; push2_addr_i = '0;
      pop_cnt_i = 2'd0;
`ifdef INST_QUEUE_BPU_CORR_EN
      push1_corr_i = '0; push2_corr_i = '0;
`endif
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_count", 32'(count_o), 32'd0);
      chk("reset_v1",    32'(out1_valid_o), 32'd0);
      chk("reset_v2",    32'(out2_valid_o), 32'd0);
      chk("reset_full",  32'(full_o), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // First pair with explicit addresses.
      push1_valid_i = 1'b1; push2_valid_i = 1'b1;
      push1_inst_i = 32'h11; push1_addr_i = 32'h1000;
      push2_inst_i = 32'h22; push2_addr_i = 32'h1004;
      @(posedge clk); #1;
      idle_inputs();
      chk("pair_count", 32'(count_o), 32'd2);
      chk("pair_inst1", out1_inst_o, 32'h11);
      chk("pair_addr1", out1_addr_o, 32'h1000);
      chk("pair_addr2", out2_addr_o, 32'h1004);
      chk("pair_v1",    32'(out1_valid_o), 32'd1);
      chk("pair_v2",    32'(out2_valid_o), 32'd1);

      //            p1 p2 i1     i2     pop fl cnt full e1     e2
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  0, 0, 32'h0,  32'h0));
      vecs.push_back(mk(1, 1, 32'h31, 32'h32, 0, 0,  2, 0, 32'h31, 32'h32));
      vecs.push_back(mk(1, 1, 32'h33, 32'h34, 0, 0,  4, 0, 32'h31, 32'h32));
      vecs.push_back(mk(1, 1, 32'h35, 32'h36, 0, 0,  6, 0, 32'h31, 32'h32));
      vecs.push_back(mk(1, 1, 32'h37, 32'h38, 0, 0,  8, 0, 32'h31, 32'h32));
      vecs.push_back(mk(1, 1, 32'h39, 32'h3A, 0, 0, 10, 0, 32'h31, 32'h32));
      vecs.push_back(mk(1, 1, 32'h3B, 32'h3C, 0, 0, 12, 0, 32'h31, 32'h32));
      vecs.push_back(mk(1, 0, 32'h3D, 32'h0,  0, 0, 13, 1, 32'h31, 32'h32));
      vecs.push_back(mk(1, 1, 32'h3E, 32'h3F, 0, 0, 15, 1, 32'h31, 32'h32));
      vecs.push_back(mk(1, 1, 32'h50, 32'h51, 0, 0, 15, 1, 32'h31, 32'h32)); // dropped
      vecs.push_back(mk(1, 0, 32'h40, 32'h0,  0, 0, 16, 1, 32'h31, 32'h32));
      vecs.push_back(mk(1, 0, 32'h99, 32'h0,  0, 0, 16, 1, 32'h31, 32'h32)); // dropped
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  3, 0, 14, 1, 32'h33, 32'h34));
      vecs.push_back(mk(1, 1, 32'h41, 32'h42, 2, 0, 14, 1, 32'h35, 32'h36));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0, 12, 0, 32'h37, 32'h38));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0, 10, 0, 32'h39, 32'h3A));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  8, 0, 32'h3B, 32'h3C));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  6, 0, 32'h3D, 32'h3E));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  4, 0, 32'h3F, 32'h40));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  2, 0, 32'h41, 32'h42));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  1, 0,  1, 0, 32'h42, 32'h0));
      vecs.push_back(mk(1, 1, 32'h61, 32'h62, 2, 0,  2, 0, 32'h61, 32'h62)); // pop clamps to 1
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  0, 0, 32'h0,  32'h0));
      vecs.push_back(mk(1, 1, 32'h70, 32'h71, 0, 0,  2, 0, 32'h70, 32'h71));
      vecs.push_back(mk(1, 1, 32'h72, 32'h73, 2, 0,  2, 0, 32'h72, 32'h73));
      vecs.push_back(mk(1, 1, 32'h74, 32'h75, 2, 0,  2, 0, 32'h74, 32'h75));
      vecs.push_back(mk(1, 1, 32'h76, 32'h77, 2, 0,  2, 0, 32'h76, 32'h77));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  0, 0, 32'h0,  32'h0));  // head=14
      vecs.push_back(mk(1, 1, 32'h81, 32'h82, 0, 0,  2, 0, 32'h81, 32'h82));
      vecs.push_back(mk(1, 1, 32'h83, 32'h84, 0, 0,  4, 0, 32'h81, 32'h82)); // wraps
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  2, 0, 32'h83, 32'h84));
      vecs.push_back(mk(0, 0, 32'h0,  32'h0,  2, 0,  0, 0, 32'h0,  32'h0));
      vecs.push_back(mk(1, 1, 32'h91, 32'h92, 0, 0,  2, 0, 32'h91, 32'h92));
      vecs.push_back(mk(1, 1, 32'h93, 32'h94, 0, 0,  4, 0, 32'h91, 32'h92));
      vecs.push_back(mk(1, 1, 32'h95, 32'h96, 0, 0,  6, 0, 32'h91, 32'h92));
      vecs.push_back(mk(1, 1, 32'hEE, 32'hEF, 1, 1,  0, 0, 32'h0,  32'h0));  // flush
      vecs.push_back(mk(1, 1, 32'hA1, 32'hA2, 0, 0,  2, 0, 32'hA1, 32'hA2));
      vecs.push_back(mk(1, 1, 32'hA3, 32'hA4, 0, 0,  4, 0, 32'hA1, 32'hA2));
      vecs.push_back(mk(1, 1, 32'hA5, 32'hA6, 0, 0,  6, 0, 32'hA1, 32'hA2));
      vecs.push_back(mk(1, 1, 32'hA7, 32'hA8, 0, 0,  8, 0, 32'hA1, 32'hA2));
      vecs.push_back(mk(1, 0, 32'hA9, 32'h0,  0, 0,  9, 0, 32'hA1, 32'hA2));
      vecs.push_back(mk(0, 1, 32'h0,  32'hBB, 0, 0,  9, 0, 32'hA1, 32'hA2)); // push2 alone ignored

      for (int k = 0; k < vecs.size(); k++) begin
         push1_valid_i = vecs[k].p1;  push2_valid_i = vecs[k].p2;
         push1_inst_i  = vecs[k].i1;  push2_inst_i  = vecs[k].i2;
         push1_addr_i  = addr_of(vecs[k].i1);
         push2_addr_i  = addr_of(vecs[k].i2);
         pop_cnt_i     = vecs[k].pop; flush = vecs[k].fl;
         @(posedge clk); #1;
         chk($sformatf("v%0d_count", k), 32'(count_o), 32'(vecs[k].cnt));
         chk($sformatf("v%0d_full", k), 32'(full_o), 32'(vecs[k].full));
         chk($sformatf("v%0d_v1", k), 32'(out1_valid_o), 32'(vecs[k].cnt >= 5'd1));
         chk($sformatf("v%0d_v2", k), 32'(out2_valid_o), 32'(vecs[k].cnt >= 5'd2));
         if (vecs[k].cnt >= 5'd1) begin
            chk($sformatf("v%0d_inst1", k), out1_inst_o, vecs[k].e1);
            chk($sformatf("v%0d_addr1", k), out1_addr_o, addr_of(vecs[k].e1));
         end
         if (vecs[k].cnt >= 5'd2) begin
            chk($sformatf("v%0d_inst2", k), out2_inst_o, vecs[k].e2);
            chk($sformatf("v%0d_addr2", k), out2_addr_o, addr_of(vecs[k].e2));
         end
      end
      idle_inputs();

      // Asynchronous reset in the middle of a cycle at count 9.
      #3;
      rst = 1'b1;
      #1;
      chk("async_rst_count", 32'(count_o), 32'd0);
      chk("async_rst_v1",    32'(out1_valid_o), 32'd0);
      chk("async_rst_v2",    32'(out2_valid_o), 32'd0);
      chk("async_rst_full",  32'(full_o), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

`ifdef INST_QUEUE_BPU_CORR_EN
      push1_valid_i = 1'b1; push2_valid_i = 1'b1;
      push1_inst_i = 32'h123; push1_addr_i = 32'h3000; push1_corr_i = 8'hA5;
      push2_inst_i = 32'h124; push2_addr_i = 32'h3004; push2_corr_i = 8'h5A;
      @(posedge clk); #1;
      idle_inputs();
      chk("corr_inst1", out1_inst_o, 32'h123);
      chk("corr_corr1", 32'(out1_corr_o), 32'hA5);
      chk("corr_corr2", 32'(out2_corr_o), 32'h5A);
      pop_cnt_i = 2'd1;
      @(posedge clk); #1;
      idle_inputs();
      chk("corr_pop_inst1", out1_inst_o, 32'h124);
      chk("corr_pop_corr1", 32'(out1_corr_o), 32'h5A);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
